// File: rtl/baser_257b_pkg.sv
// Shared widths, sync headers, block-type table and transcoded block layout
// for the BASE-R 257b receive decoder.
package baser_257b_pkg;

   localparam int DATA_WIDTH    = 64;
   localparam int HDR_WIDTH     = 2;
   localparam int FRAME_WIDTH   = DATA_WIDTH + HDR_WIDTH;
   localparam int TC_DATA_WIDTH = 4 * DATA_WIDTH;
   localparam int TC_HDR_WIDTH  = 1;
   localparam int TC_WIDTH      = TC_DATA_WIDTH + TC_HDR_WIDTH;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   localparam logic [7:0] BT_1E = 8'h1E;
   localparam logic [7:0] BT_2D = 8'h2D;
   localparam logic [7:0] BT_33 = 8'h33;
   localparam logic [7:0] BT_4B = 8'h4B;
   localparam logic [7:0] BT_55 = 8'h55;
   localparam logic [7:0] BT_66 = 8'h66;
   localparam logic [7:0] BT_78 = 8'h78;
   localparam logic [7:0] BT_87 = 8'h87;
   localparam logic [7:0] BT_99 = 8'h99;
   localparam logic [7:0] BT_AA = 8'hAA;
   localparam logic [7:0] BT_B4 = 8'hB4;
   localparam logic [7:0] BT_CC = 8'hCC;
   localparam logic [7:0] BT_D2 = 8'hD2;
   localparam logic [7:0] BT_E1 = 8'hE1;
   localparam logic [7:0] BT_FF = 8'hFF;

   // Control block made of eight /E/ characters, used to poison invalid input
   localparam logic [FRAME_WIDTH-1:0] ERR_BLOCK = {{8{7'h1E}}, BT_1E, SH_CTRL};

   typedef struct packed {
      logic [TC_DATA_WIDTH-1:0] payload;
      logic                     hdr;
   } tc_block_t;

   typedef enum logic {ST_GOOD, ST_HI_ERR} mon_state_t;

   // Rebuild a full type byte from its high nibble; 8'h00 marks nibble 0 (no type)
   function automatic logic [7:0] nibble_to_type(input logic [3:0] nib);
      case (nib)
         4'h1:    return BT_1E;
         4'h2:    return BT_2D;
         4'h3:    return BT_33;
         4'h4:    return BT_4B;
         4'h5:    return BT_55;
         4'h6:    return BT_66;
         4'h7:    return BT_78;
         4'h8:    return BT_87;
         4'h9:    return BT_99;
         4'hA:    return BT_AA;
         4'hB:    return BT_B4;
         4'hC:    return BT_CC;
         4'hD:    return BT_D2;
         4'hE:    return BT_E1;
         4'hF:    return BT_FF;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic is_valid_type(input logic [7:0] bt);
      case (bt)
         BT_1E, BT_2D, BT_33, BT_4B, BT_55, BT_66, BT_78, BT_87,
         BT_99, BT_AA, BT_B4, BT_CC, BT_D2, BT_E1, BT_FF: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/baser_257b_rx_decoder_mon_err_mon.sv
// Windowed error-rate monitor: flags hi_err when a full window of blocks
// held ERR_THRESH or more invalid ones; re-evaluated at each window end.
module baser_257b_err_mon
   import baser_257b_pkg::*;
#(
   parameter int WINDOW_BLOCKS = 1024,
   parameter int ERR_THRESH    = 16
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_valid,
   input  logic i_inv,
   output logic o_hi_err
);

   localparam int WW = $clog2(WINDOW_BLOCKS);
   localparam int EW = $clog2(WINDOW_BLOCKS + 1);

   mon_state_t      state_q;
   logic [WW-1:0]   win_q;
   logic [EW-1:0]   err_q;
   logic [EW-1:0]   err_tot;

   // the window's last block counts toward the decision it closes
   assign err_tot  = err_q + EW'(i_inv);
   assign o_hi_err = (state_q == ST_HI_ERR);

   // window/error counters and the state decision at each window boundary
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= ST_GOOD;
         win_q   <= '0;
         err_q   <= '0;
      end else if (i_valid) begin
         if (win_q == WW'(WINDOW_BLOCKS - 1)) begin
            win_q   <= '0;
            err_q   <= '0;
            state_q <= (int'(err_tot) >= ERR_THRESH) ? ST_HI_ERR : ST_GOOD;
         end else begin
            win_q <= win_q + 1'b1;
            err_q <= err_tot;
         end
      end
   end

endmodule

// File: rtl/baser_257b_rx_decoder_mon.sv
// 257b -> 4x66b receive decoder with validation, optional error substitution,
// saturating statistics and a high-error-rate monitor. Two-stage pipeline.
module baser_257b_rx_decoder_mon
   import baser_257b_pkg::*;
#(
   parameter int CNT_WIDTH     = 32,
   parameter int WINDOW_BLOCKS = 1024,
   parameter int ERR_THRESH    = 16,
   parameter bit SUBST_ERR     = 1'b1
) (
   input  logic                   clk,
   input  logic                   i_rst,
   input  logic                   i_valid,
   input  logic [TC_WIDTH-1:0]    i_rx_xcoded,
   input  logic                   i_cnt_clear,
   output logic                   o_valid,
   output logic [FRAME_WIDTH-1:0] o_rx_coded_0,
   output logic [FRAME_WIDTH-1:0] o_rx_coded_1,
   output logic [FRAME_WIDTH-1:0] o_rx_coded_2,
   output logic [FRAME_WIDTH-1:0] o_rx_coded_3,
   output logic                   o_block_err,
   output logic [CNT_WIDTH-1:0]   o_block_count,
   output logic [CNT_WIDTH-1:0]   o_data_count,
   output logic [CNT_WIDTH-1:0]   o_ctrl_count,
   output logic [CNT_WIDTH-1:0]   o_inv_block_count,
   output logic                   o_hi_err
);

   tc_block_t                    blk;
   logic [3:0]                   flags;
   logic [319:0]                 pad;      // room for the worst-case field walk
   logic [1:0]                   first_c;
   logic [8:0]                   off;
   logic [3:0][FRAME_WIDTH-1:0]  dec;
   logic                         dec_inv;

   // S1 decode: walk the packed fields; the first control block is compressed
   always_comb begin
      blk     = tc_block_t'(i_rx_xcoded);
      flags   = i_rx_xcoded[4:1];
      pad     = {63'b0, i_rx_xcoded};
      first_c = 2'd0;
      for (int k = 3; k >= 0; k--)
         if (!flags[k]) first_c = 2'(k);
      dec     = '0;
      dec_inv = 1'b0;
      off     = 9'd5;
      if (blk.hdr) begin
         for (int k = 0; k < 4; k++)
            dec[k] = {blk.payload[64*k +: 64], SH_DATA};
      end else begin
         dec_inv = (flags == 4'hF);
         for (int k = 0; k < 4; k++) begin
            if (flags[k]) begin
               dec[k] = {pad[off +: 64], SH_DATA};
               off    = off + 9'd64;
            end else if (first_c == 2'(k)) begin
               dec[k] = {pad[off + 4 +: 56], nibble_to_type(pad[off +: 4]), SH_CTRL};
               if (pad[off +: 4] == 4'h0) dec_inv = 1'b1;
               off    = off + 9'd60;
            end else begin
               dec[k] = {pad[off +: 64], SH_CTRL};
               if (!is_valid_type(pad[off +: 8])) dec_inv = 1'b1;
               off    = off + 9'd64;
            end
         end
      end
   end

   // saturating counter step; clear wins but still records a same-cycle event
   function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                     input logic ev, input logic clr);
      if (clr)              return ev ? CNT_WIDTH'(1) : '0;
      if (ev && (c != '1))  return c + 1'b1;
      return c;
   endfunction

   logic [CNT_WIDTH-1:0] blk_cnt_q, data_cnt_q, ctrl_cnt_q, inv_cnt_q;
   logic [CNT_WIDTH-1:0] blk_cnt_d, data_cnt_d, ctrl_cnt_d, inv_cnt_d;

   // next-state of the statistics, evaluated on the incoming block
   always_comb begin
      blk_cnt_d  = cnt_next(blk_cnt_q,  i_valid, i_cnt_clear);
      data_cnt_d = cnt_next(data_cnt_q, i_valid & blk.hdr, i_cnt_clear);
      ctrl_cnt_d = cnt_next(ctrl_cnt_q, i_valid & ~blk.hdr & ~dec_inv, i_cnt_clear);
      inv_cnt_d  = cnt_next(inv_cnt_q,  i_valid & dec_inv, i_cnt_clear);
   end

   // statistics registers
   always_ff @(posedge clk) begin
      if (i_rst) begin
         blk_cnt_q  <= '0;
         data_cnt_q <= '0;
         ctrl_cnt_q <= '0;
         inv_cnt_q  <= '0;
      end else begin
         blk_cnt_q  <= blk_cnt_d;
         data_cnt_q <= data_cnt_d;
         ctrl_cnt_q <= ctrl_cnt_d;
         inv_cnt_q  <= inv_cnt_d;
      end
   end

   logic                         s1_vld_q, s1_inv_q;
   logic [3:0][FRAME_WIDTH-1:0]  s1_blk_q;

   // S1 register: decoded group plus its validity
   always_ff @(posedge clk) begin
      if (i_rst) begin
         s1_vld_q <= 1'b0;
         s1_inv_q <= 1'b0;
         s1_blk_q <= '0;
      end else begin
         s1_vld_q <= i_valid;
         if (i_valid) begin
            s1_inv_q <= dec_inv;
            s1_blk_q <= dec;
         end
      end
   end

   logic [3:0][FRAME_WIDTH-1:0]  sub_blk;
   logic                         out_vld_q, out_err_q;
   logic [3:0][FRAME_WIDTH-1:0]  out_blk_q;

   // S2 substitution of invalid groups with error blocks
   always_comb begin
      sub_blk = s1_blk_q;
      if (SUBST_ERR && s1_inv_q) sub_blk = {4{ERR_BLOCK}};
   end

   // S2 output register; data holds across bubbles
   always_ff @(posedge clk) begin
      if (i_rst) begin
         out_vld_q <= 1'b0;
         out_err_q <= 1'b0;
         out_blk_q <= '0;
      end else begin
         out_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            out_err_q <= s1_inv_q;
            out_blk_q <= sub_blk;
         end
      end
   end

   baser_257b_err_mon #(
      .WINDOW_BLOCKS (WINDOW_BLOCKS),
      .ERR_THRESH    (ERR_THRESH)
   ) u_err_mon (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .i_inv    (dec_inv),
      .o_hi_err (o_hi_err)
   );

   assign o_valid           = out_vld_q;
   assign o_block_err       = out_err_q;
   assign o_rx_coded_0      = out_blk_q[0];
   assign o_rx_coded_1      = out_blk_q[1];
   assign o_rx_coded_2      = out_blk_q[2];
   assign o_rx_coded_3      = out_blk_q[3];
   assign o_block_count     = blk_cnt_q;
   assign o_data_count      = data_cnt_q;
   assign o_ctrl_count      = ctrl_cnt_q;
   assign o_inv_block_count = inv_cnt_q;

endmodule

// File: tb/tb_baser_257b_rx_decoder_mon.sv
// Directed bench for the 257b decoder: decode, substitution, counters, monitor.
module tb_baser_257b_rx_decoder_mon;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          i_rst, i_valid, i_cnt_clear;
   logic [256:0]  i_rx_xcoded;
   logic          o_valid, o_block_err, o_hi_err;
   logic [65:0]   o_rx_coded_0, o_rx_coded_1, o_rx_coded_2, o_rx_coded_3;
   logic [CW-1:0] o_block_count, o_data_count, o_ctrl_count, o_inv_block_count;

   baser_257b_rx_decoder_mon #(
      .CNT_WIDTH(CW), .WINDOW_BLOCKS(8), .ERR_THRESH(2), .SUBST_ERR(1'b1)
   ) dut (
      .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_rx_xcoded(i_rx_xcoded),
      .i_cnt_clear(i_cnt_clear), .o_valid(o_valid),
      .o_rx_coded_0(o_rx_coded_0), .o_rx_coded_1(o_rx_coded_1),
      .o_rx_coded_2(o_rx_coded_2), .o_rx_coded_3(o_rx_coded_3),
      .o_block_err(o_block_err), .o_block_count(o_block_count),
      .o_data_count(o_data_count), .o_ctrl_count(o_ctrl_count),
      .o_inv_block_count(o_inv_block_count), .o_hi_err(o_hi_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [65:0] act, input logic [65:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic push(input logic v, input logic [256:0] x);
      i_valid     = v;
      i_rx_xcoded = x;
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input string tag, input int b, input int d, input int c, input int inv);
      check({tag, "_blk"},  66'(o_block_count),     66'(b));
      check({tag, "_data"}, 66'(o_data_count),      66'(d));
      check({tag, "_ctrl"}, 66'(o_ctrl_count),      66'(c));
      check({tag, "_inv"},  66'(o_inv_block_count), 66'(inv));
   endtask

   // hand-built vectors
   logic [256:0] A, B, C, D, E;
   logic [65:0]  A_OUT, ERR;
   logic [256:0] w1 [8];
   logic [256:0] w2 [9];
   logic         w2v [9];

   initial begin
      A     = {{32{8'hAA}}, 1'b1};
      A_OUT = {64'hAAAA_AAAA_AAAA_AAAA, 2'b01};
      B     = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111,
               {7{8'hAA}}, 4'h7, 4'b1110, 1'b0};
      C     = {252'h0, 4'hF, 1'b0};
      D     = {64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555, 64'h0123_4567_89AB_CD00,
               56'h0, 4'h1, 4'b1100, 1'b0};
      E     = {64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555, 64'h0123_4567_89AB_CD2D,
               56'h0, 4'h1, 4'b1100, 1'b0};
      ERR   = {{8{7'h1E}}, 8'h1E, 2'b10};

      // reset held with traffic present
      i_rst = 1'b1; i_valid = 1'b1; i_rx_xcoded = A; i_cnt_clear = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("rst_ovalid", 66'(o_valid), 66'(0));
      end
      check("rst_c0", o_rx_coded_0, 66'(0));
      check("rst_c3", o_rx_coded_3, 66'(0));
      check("rst_err", 66'(o_block_err), 66'(0));
      check("rst_hi", 66'(o_hi_err), 66'(0));
      check_cnt("rst", 0, 0, 0, 0);
      i_rst = 1'b0;

      // all-data block
      push(1'b1, A);
      check_cnt("a", 1, 1, 0, 0);
      push(1'b0, '0);
      check("a_vld", 66'(o_valid), 66'(1));
      check("a_c0", o_rx_coded_0, A_OUT);
      check("a_c1", o_rx_coded_1, A_OUT);
      check("a_c2", o_rx_coded_2, A_OUT);
      check("a_c3", o_rx_coded_3, A_OUT);
      check("a_err", 66'(o_block_err), 66'(0));

      // bubble then first-control block
      push(1'b1, B);
      check("bub_vld", 66'(o_valid), 66'(0));
      check("bub_hold", o_rx_coded_0, A_OUT);
      push(1'b0, '0);
      check("b_vld", 66'(o_valid), 66'(1));
      check("b_c0", o_rx_coded_0, {{7{8'hAA}}, 8'h78, 2'b10});
      check("b_c1", o_rx_coded_1, {64'h1111_1111_1111_1111, 2'b01});
      check("b_c2", o_rx_coded_2, {64'h2222_2222_2222_2222, 2'b01});
      check("b_c3", o_rx_coded_3, {64'h3333_3333_3333_3333, 2'b01});
      check_cnt("b", 2, 1, 1, 0);

      // invalid flags, invalid second type, valid two-control block back-to-back
      push(1'b1, C);
      push(1'b1, D);
      check("c_err", 66'(o_block_err), 66'(1));
      check("c_c0", o_rx_coded_0, ERR);
      check("c_c2", o_rx_coded_2, ERR);
      push(1'b1, E);
      check("d_err", 66'(o_block_err), 66'(1));
      check("d_c1", o_rx_coded_1, ERR);
      check("d_c3", o_rx_coded_3, ERR);
      push(1'b0, '0);
      check("e_vld", 66'(o_valid), 66'(1));
      check("e_err", 66'(o_block_err), 66'(0));
      check("e_c0", o_rx_coded_0, {56'h0, 8'h1E, 2'b10});
      check("e_c1", o_rx_coded_1, {64'h0123_4567_89AB_CD2D, 2'b10});
      check("e_c2", o_rx_coded_2, {64'h5555_5555_5555_5555, 2'b01});
      check("e_c3", o_rx_coded_3, {64'h4444_4444_4444_4444, 2'b01});
      check_cnt("cde", 5, 1, 2, 2);
      check("cde_hi", 66'(o_hi_err), 66'(0));

      // reset mid-stream drops the in-flight block
      push(1'b1, A);
      i_rst = 1'b1;
      push(1'b1, A);
      check("midrst_vld", 66'(o_valid), 66'(0));
      push(1'b0, '0);
      i_rst = 1'b0;

      // window 1: two invalid, the second being the window's last block
      w1 = '{A, C, A, A, A, A, A, C};
      for (int i = 0; i < 8; i++) begin
         push(1'b1, w1[i]);
         if (i == 6) check("w1_pre_hi", 66'(o_hi_err), 66'(0));
      end
      check("w1_hi", 66'(o_hi_err), 66'(1));

      // window 2: one invalid and a bubble that must not count
      w2  = '{A, A, '0, A, C, A, A, A, A};
      w2v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 9; i++) begin
         push(w2v[i], w2[i]);
         if (i == 7) check("w2_pre_hi", 66'(o_hi_err), 66'(1));
      end
      check("w2_hi", 66'(o_hi_err), 66'(0));

      // 16 blocks through 4-bit counters: block count saturated
      check_cnt("sat", 15, 13, 0, 3);
      push(1'b1, A);
      check_cnt("sat2", 15, 14, 0, 3);

      // clear concurrent with an invalid block, then clear alone
      i_cnt_clear = 1'b1;
      push(1'b1, C);
      i_cnt_clear = 1'b0;
      check_cnt("clr_ev", 1, 0, 0, 1);
      i_cnt_clear = 1'b1;
      push(1'b0, '0);
      i_cnt_clear = 1'b0;
      check_cnt("clr", 0, 0, 0, 0);

      push(1'b0, '0);
      push(1'b0, '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
